// File: rtl/otter_enc_pkg.sv
// Shared types and constants for the Otter instruction encoder.
package otter_enc_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_t;

   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   localparam int OPC_W   = 7;
   localparam int REG_W   = 5;
   localparam int F3_W    = 3;
   localparam int F7_W    = 7;
   localparam int IMM_W   = 32;
   localparam int INSTR_W = 32;

   // fmt kept as raw bits so the illegal codes 6/7 survive into the packer
   typedef struct packed {
      logic [2:0]       fmt;
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
      logic [IMM_W-1:0] imm;
   } enc_fields_t;

   // True when v[31:lsb] are all equal, i.e. v fits as a sign-extended value
   // whose top bit is lsb.
   function automatic logic sext_ok(input logic [31:0] v, input int unsigned lsb);
      logic signed [31:0] s;
      s = $signed(v) >>> lsb;
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: decoded fields + immediate -> 32-bit word and range error.
module imm_pack
   import otter_enc_pkg::*;
(
   input  enc_fields_t        f,
   output logic [INSTR_W-1:0] instr,
   output logic               err
);

   // Select the bit layout for the format and flag immediates that do not fit.
   always_comb begin
      instr = '0;
      err   = 1'b0;
      case (f.fmt)
         FMT_R: instr = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
         FMT_I: begin
            instr = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            err   = !sext_ok(f.imm, 11);
         end
         FMT_S: begin
            instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            err   = !sext_ok(f.imm, 11);
         end
         FMT_B: begin
            instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                     f.imm[4:1], f.imm[11], f.opcode};
            err   = !sext_ok(f.imm, 12) || f.imm[0];
         end
         FMT_U: begin
            instr = {f.imm[31:12], f.rd, f.opcode};
            err   = (f.imm[11:0] != 12'd0);
         end
         FMT_J: begin
            instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            err   = !sext_ok(f.imm, 20) || f.imm[0];
         end
         // illegal format: emit a zero word flagged as an error
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder with saturating statistics.
// Stage 1 holds the raw fields, stage 2 holds the packed word and error flag.
module instr_encoder
   import otter_enc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         fmt,
   input  logic [OPC_W-1:0]   opcode,
   input  logic [REG_W-1:0]   rd,
   input  logic [REG_W-1:0]   rs1,
   input  logic [REG_W-1:0]   rs2,
   input  logic [F3_W-1:0]    funct3,
   input  logic [F7_W-1:0]    funct7,
   input  logic [IMM_W-1:0]   imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic               out_err,
   output logic [CNT_W-1:0]   enc_count,
   output logic [CNT_W-1:0]   err_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   enc_fields_t        s1_q, s1_d;
   logic               s1_valid_q, s1_valid_d;
   logic               s2_valid_q, s2_valid_d;
   logic [INSTR_W-1:0] s2_instr_q, s2_instr_d;
   logic               s2_err_q, s2_err_d;
   logic [CNT_W-1:0]   enc_cnt_q, enc_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic [INSTR_W-1:0] pk_instr;
   logic               pk_err;
   logic               s2_load, in_fire, out_fire;

   imm_pack u_pack (
      .f     (s1_q),
      .instr (pk_instr),
      .err   (pk_err)
   );

   // Handshake, next-state for both stages and counters.
   always_comb begin
      s2_load  = !s2_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_load;
      in_fire  = in_valid && in_ready;
      out_fire = s2_valid_q && out_ready;

      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      s2_instr_d = s2_instr_q;
      s2_err_d   = s2_err_q;
      enc_cnt_d  = enc_cnt_q;
      err_cnt_d  = err_cnt_q;

      // stage 2 takes whatever stage 1 holds (possibly a bubble) when free
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_instr_d = pk_instr;
            s2_err_d   = pk_err;
         end
      end

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_d       = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                        funct3: funct3, funct7: funct7, imm: imm};
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (out_fire) begin
         if (enc_cnt_q != CNT_MAX) enc_cnt_d = enc_cnt_q + 1'b1;
         if (s2_err_q && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // Pipeline and counter registers; reset drops all in-flight words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_instr_q <= '0;
         s2_err_q   <= 1'b0;
         enc_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_instr_q <= s2_instr_d;
         s2_err_q   <= s2_err_d;
         enc_cnt_q  <= enc_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_instr = s2_instr_q;
   assign out_err   = s2_err_q;
   assign enc_count = enc_cnt_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

   localparam int CW = 4;   // small counters so saturation is reachable

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    fmt = '0;
   logic [6:0]    opcode = '0;
   logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]    funct3 = '0;
   logic [6:0]    funct7 = '0;
   logic [31:0]   imm = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_instr;
   logic          out_err;
   logic [CW-1:0] enc_count, err_count;

   int n_checks = 0;
   int n_errors = 0;

   // vector tables
   logic [2:0]  v_fmt [32];
   logic [6:0]  v_op  [32];
   logic [4:0]  v_rd  [32], v_rs1 [32], v_rs2 [32];
   logic [2:0]  v_f3  [32];
   logic [6:0]  v_f7  [32];
   logic [31:0] v_imm [32];
   logic [31:0] e_instr [32];
   logic        e_err   [32];

   // captured outputs
   logic [31:0] cap_instr [32];
   logic        cap_err   [32];
   int          cap_cyc   [32];
   int          ncap;
   int          snap_acc;
   logic        snap_in_ready;
   int          stable_bad;

   instr_encoder #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic load_vec(input int i, input logic [2:0] f, input logic [6:0] op,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                           input logic [31:0] ei, input logic ee);
      v_fmt[i] = f; v_op[i] = op; v_rd[i] = d; v_rs1[i] = s1; v_rs2[i] = s2;
      v_f3[i] = f3; v_f7[i] = f7; v_imm[i] = im; e_instr[i] = ei; e_err[i] = ee;
   endtask

   task automatic drive_vec(input int i);
      fmt = v_fmt[i]; opcode = v_op[i]; rd = v_rd[i]; rs1 = v_rs1[i]; rs2 = v_rs2[i];
      funct3 = v_f3[i]; funct7 = v_f7[i]; imm = v_imm[i];
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Streams n table vectors; out_ready held low for the first `hold` cycles.
   // Captures delivered words; bounded, so a stuck DUT just yields ncap < n.
   task automatic run_stream(input int n, input int hold);
      int acc = 0;
      logic stalled = 1'b0;
      logic [31:0] prev = '0;
      ncap = 0; stable_bad = 0; snap_acc = -1; snap_in_ready = 1'bx;
      for (int cyc = 0; cyc < n + hold + 20 && ncap < n; cyc++) begin
         out_ready = (cyc >= hold);
         if (acc < n) begin drive_vec(acc); in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(negedge clk);
         if (cyc == hold - 1) begin snap_acc = acc; snap_in_ready = in_ready; end
         if (stalled && (!out_valid || out_instr !== prev)) stable_bad++;
         stalled = out_valid && !out_ready;
         prev = out_instr;
         if (out_valid && out_ready) begin
            cap_instr[ncap] = out_instr; cap_err[ncap] = out_err;
            cap_cyc[ncap] = cyc; ncap++;
         end
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: valid=%b instr=%h err=%b, want 0/0/0", out_valid, out_instr, out_err);
      end
      n_checks++;
      if (enc_count !== '0 || err_count !== '0) begin
         n_errors++;
         $display("FAIL reset_counters: enc=%0d err=%0d, want 0/0", enc_count, err_count);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_latency();
      load_vec(0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
      out_ready = 1'b1;
      drive_vec(0); in_valid = 1'b1;
      @(posedge clk); #1;           // accept edge
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL latency_early: out_valid=%b one edge after accept, want 0", out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_err !== 1'b0) begin
         n_errors++;
         $display("FAIL latency_word: valid=%b instr=%h err=%b, want 1/00500093/0", out_valid, out_instr, out_err);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || enc_count !== 4'd1 || err_count !== 4'd0) begin
         n_errors++;
         $display("FAIL latency_drain: valid=%b enc=%0d err=%0d, want 0/1/0", out_valid, enc_count, err_count);
      end
   endtask

   task automatic test_formats();
      do_reset();
      load_vec(0,  3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,    32'd8,        32'h0020A423, 1'b0);
      load_vec(1,  3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
      load_vec(2,  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00000800, 32'h001000EF, 1'b0);
      load_vec(3,  3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345000, 32'h123452B7, 1'b0);
      load_vec(4,  3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20,   32'hFFFFFFFF, 32'h403100B3, 1'b0);
      load_vec(5,  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFF800, 32'h80000093, 1'b0);
      load_vec(6,  3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,    32'hFFFFFFFF, 32'hFE20AFA3, 1'b0);
      load_vec(7,  3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345001, 32'h123452B7, 1'b1);
      load_vec(8,  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00100000, 32'h800000EF, 1'b1);
      load_vec(9,  3'd6, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h7F,   32'h00000004, 32'h00000000, 1'b1);
      load_vec(10, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFF00000, 32'h800000EF, 1'b0);
      load_vec(11, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00001000, 32'h80000063, 1'b1);
      run_stream(12, 0);
      n_checks++;
      if (ncap !== 12) begin
         n_errors++;
         $display("FAIL formats_count: delivered %0d words, want 12", ncap);
      end
      for (int i = 0; i < ncap; i++) begin
         n_checks++;
         if (cap_instr[i] !== e_instr[i] || cap_err[i] !== e_err[i]) begin
            n_errors++;
            $display("FAIL formats_vec%0d: instr=%h err=%b, want %h/%b", i, cap_instr[i], cap_err[i], e_instr[i], e_err[i]);
         end
      end
      n_checks++;
      if (enc_count !== 4'd12 || err_count !== 4'd4) begin
         n_errors++;
         $display("FAIL formats_counters: enc=%0d err=%0d, want 12/4", enc_count, err_count);
      end
   endtask

   task automatic test_err_counts();
      do_reset();
      load_vec(0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1);
      load_vec(1, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6,    32'h00000363, 1'b0);
      load_vec(2, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,    32'h00000163, 1'b1);
      run_stream(3, 0);
      n_checks++;
      if (ncap !== 3) begin
         n_errors++;
         $display("FAIL errcnt_count: delivered %0d, want 3", ncap);
      end
      for (int i = 0; i < ncap; i++) begin
         n_checks++;
         if (cap_instr[i] !== e_instr[i] || cap_err[i] !== e_err[i]) begin
            n_errors++;
            $display("FAIL errcnt_vec%0d: instr=%h err=%b, want %h/%b", i, cap_instr[i], cap_err[i], e_instr[i], e_err[i]);
         end
      end
      n_checks++;
      if (enc_count !== 4'd3 || err_count !== 4'd2) begin
         n_errors++;
         $display("FAIL errcnt_counters: enc=%0d err=%0d, want 3/2", enc_count, err_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      load_vec(0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093, 1'b0);
      load_vec(1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200093, 1'b0);
      load_vec(2, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300093, 1'b0);
      run_stream(3, 5);
      n_checks++;
      if (snap_acc !== 2 || snap_in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_accept: accepted=%0d in_ready=%b while stalled, want 2/0", snap_acc, snap_in_ready);
      end
      n_checks++;
      if (stable_bad !== 0) begin
         n_errors++;
         $display("FAIL stall_stable: %0d stalled cycles changed output, want 0", stable_bad);
      end
      n_checks++;
      if (ncap !== 3) begin
         n_errors++;
         $display("FAIL stall_count: delivered %0d, want 3", ncap);
      end
      for (int i = 0; i < ncap; i++) begin
         n_checks++;
         if (cap_instr[i] !== e_instr[i]) begin
            n_errors++;
            $display("FAIL stall_order%0d: instr=%h, want %h", i, cap_instr[i], e_instr[i]);
         end
      end
      n_checks++;
      if (ncap == 3 && (cap_cyc[1] != cap_cyc[0] + 1 || cap_cyc[2] != cap_cyc[1] + 1)) begin
         n_errors++;
         $display("FAIL stall_b2b: output cycles %0d,%0d,%0d, want consecutive", cap_cyc[0], cap_cyc[1], cap_cyc[2]);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 16; i++)
         load_vec(i, 3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
      load_vec(16, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
      run_stream(17, 0);
      n_checks++;
      if (ncap !== 17) begin
         n_errors++;
         $display("FAIL sat_count: delivered %0d, want 17", ncap);
      end
      n_checks++;
      if (enc_count !== 4'd15 || err_count !== 4'd15) begin
         n_errors++;
         $display("FAIL sat_counters: enc=%0d err=%0d, want 15/15", enc_count, err_count);
      end
   endtask

   task automatic test_reset_midflight();
      int bad = 0;
      do_reset();
      load_vec(0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h00700093, 1'b0);
      load_vec(1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h00800093, 1'b0);
      run_stream(1, 0);            // leaves enc_count = 1
      out_ready = 1'b0;
      drive_vec(0); in_valid = 1'b1;
      @(posedge clk); #1;
      drive_vec(1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || enc_count !== 4'd1) begin
         n_errors++;
         $display("FAIL midrst_full: valid=%b in_ready=%b enc=%0d, want 1/0/1", out_valid, in_ready, enc_count);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'd0 || enc_count !== '0 || err_count !== '0) begin
         n_errors++;
         $display("FAIL midrst_async: valid=%b instr=%h enc=%0d err=%0d, want 0/0/0/0", out_valid, out_instr, enc_count, err_count);
      end
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0 || enc_count !== '0) begin
         n_errors++;
         $display("FAIL midrst_stale: %0d cycles with out_valid, enc=%0d, want 0/0", bad, enc_count);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_formats();
      test_err_counts();
      test_back_to_back();
      test_saturation();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
